shift_seq_8_bit: RTL and testbench

Multi-cycle shift/rotate sequencer that drives the combinational 8-bit shifter (shift_8_bit) one bit position per clock. It sits directly upstream of the shifter: it supplies D, shift_in_right, shift_in_left and select. It captures S and the borrow bits (bb_right/bb_left) back into its working register and carry flag. Shifts of 0..7 positions are applied with logical, rotate, arithmetic and rotate-through-carry modes, and the result is presented with a one-cycle done pulse for the ALU result mux.

---
 rtl/shift_seq_8_bit_pkg.sv | 26 ++
 rtl/shift_8_bit.sv | 27 ++
 rtl/shift_seq_8_bit.sv | 142 ++++++++++++++
 tb/tb_shift_seq_8_bit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_8_bit_pkg.sv
// ---------------------------------------------------------------------------
// shift_seq_8_bit_pkg
//   Shared types and constants for the multi-cycle shift/rotate sequencer.
//   - state_t : sequencer FSM states (idle, shifting, done pulse)
//   - mode_t  : shift modes as presented on the 2-bit mode input
//   - DIR_*   : direction encoding shared with shift_8_bit's select input
// ---------------------------------------------------------------------------
package shift_seq_8_bit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        MODE_LOGICAL = 2'b00,
        MODE_ROTATE  = 2'b01,
        MODE_ARITH   = 2'b10,
        MODE_RCC     = 2'b11
    } mode_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_8_bit.sv
// ---------------------------------------------------------------------------
// shift_8_bit
//   Combinational one-position 8-bit shifter.
//   Ports:
//     D              in  [7:0] operand
//     shift_in_right in        bit entering at bit 0 on a left shift
//     shift_in_left  in        bit entering at bit 7 on a right shift
//     select         in        0 = shift left, 1 = shift right
//     S              out [7:0] shifted value
//     bb_right       out       bit leaving on a right shift (D[0])
//     bb_left        out       bit leaving on a left shift  (D[7])
// ---------------------------------------------------------------------------
module shift_8_bit (
    input  logic [7:0] D,
    input  logic       shift_in_right,
    input  logic       shift_in_left,
    input  logic       select,
    output logic [7:0] S,
    output logic       bb_right,
    output logic       bb_left
);

    assign S        = select ? {shift_in_left, D[7:1]} : {D[6:0], shift_in_right};
    assign bb_right = D[0];
    assign bb_left  = D[7];

endmodule

// File: rtl/shift_seq_8_bit.sv
// ---------------------------------------------------------------------------
// shift_seq_8_bit
//   Sequences shift_8_bit one bit position per clock to apply a shift of
//   0..7 positions in logical, rotate, arithmetic or rotate-through-carry
//   mode, then presents the result with a one-cycle done pulse.
//   Ports:
//     clk       in        rising-edge clock
//     rst_n     in        synchronous reset, active-low
//     start     in        request, only honoured in IDLE
//     D_in      in  [7:0] operand
//     amount    in  [2:0] shift count 0..7
//     select    in        0 = left, 1 = right
//     mode      in  [1:0] 00 logical, 01 rotate, 10 arithmetic, 11 RCC
//     carry_in  in        initial carry flag
//     result    out [7:0] working register, final when done=1
//     carry_out out       last bit shifted out (carry_in when amount=0)
//     busy      out       high while shifting
//     done      out       one-cycle completion pulse
// ---------------------------------------------------------------------------
module shift_seq_8_bit
    import shift_seq_8_bit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] D_in,
    input  logic [2:0] amount,
    input  logic       select,
    input  logic [1:0] mode,
    input  logic       carry_in,
    output logic [7:0] result,
    output logic       carry_out,
    output logic       busy,
    output logic       done
);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] counter;
    logic       dir_q;
    mode_t      mode_q;

    logic       fill_bit;
    logic       sin_right;
    logic       sin_left;
    logic [7:0] s_out;
    logic       bb_right;
    logic       bb_left;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: a default assignment ahead of the case keeps every path
    // assigned, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = (amount != 3'd0) ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (counter == 3'd1) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state == ST_SHIFT);
        done = (state == ST_DONE);
    end

    // ------------------------------------------------------------------
    // Vacated-end fill bit; the shift_in on the non-vacated side is 0.
    // ------------------------------------------------------------------
    always_comb begin
        fill_bit = 1'b0;
        case (mode_q)
            MODE_LOGICAL: fill_bit = 1'b0;
            MODE_ROTATE:  fill_bit = (dir_q == DIR_RIGHT) ? result[0] : result[7];
            MODE_ARITH:   fill_bit = (dir_q == DIR_RIGHT) ? result[7] : 1'b0;
            MODE_RCC:     fill_bit = carry_out;
            default:      fill_bit = 1'b0;
        endcase
        sin_right = (dir_q == DIR_LEFT)  ? fill_bit : 1'b0;
        sin_left  = (dir_q == DIR_RIGHT) ? fill_bit : 1'b0;
    end

    shift_8_bit u_shift (
        .D              (result),
        .shift_in_right (sin_right),
        .shift_in_left  (sin_left),
        .select         (dir_q),
        .S              (s_out),
        .bb_right       (bb_right),
        .bb_left        (bb_left)
    );

    // ------------------------------------------------------------------
    // Datapath: operand/flag capture in IDLE, one shift per SHIFT cycle.
    // Operands are latched at acceptance so input changes afterwards have
    // no effect on an operation in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result    <= 8'h00;
            carry_out <= 1'b0;
            counter   <= 3'd0;
            dir_q     <= DIR_LEFT;
            mode_q    <= MODE_LOGICAL;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        result    <= D_in;
                        carry_out <= carry_in;
                        counter   <= amount;
                        dir_q     <= select;
                        mode_q    <= mode_t'(mode);
                    end
                end
                ST_SHIFT: begin
                    result    <= s_out;
                    carry_out <= (dir_q == DIR_RIGHT) ? bb_right : bb_left;
                    counter   <= counter - 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_8_bit.sv
// ---------------------------------------------------------------------------
// tb_shift_seq_8_bit
//   Directed self-checking bench for shift_seq_8_bit. Inputs are driven and
//   outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_shift_seq_8_bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] D_in;
    logic [2:0] amount;
    logic       select;
    logic [1:0] mode;
    logic       carry_in;
    logic [7:0] result;
    logic       carry_out;
    logic       busy;
    logic       done;

    int n_compared   = 0;
    int n_mismatched = 0;

    shift_seq_8_bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .D_in      (D_in),
        .amount    (amount),
        .select    (select),
        .mode      (mode),
        .carry_in  (carry_in),
        .result    (result),
        .carry_out (carry_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge, then scramble the inputs so that any
    // dependence on post-acceptance inputs shows up as a wrong result.
    task automatic issue(input logic [7:0] d, input logic [2:0] amt, input logic sel,
                         input logic [1:0] md, input logic cin);
        start    = 1'b1;
        D_in     = d;
        amount   = amt;
        select   = sel;
        mode     = md;
        carry_in = cin;
        step();
        start    = 1'b0;
        D_in     = ~d;
        amount   = ~amt;
        select   = ~sel;
        mode     = ~md;
        carry_in = ~cin;
    endtask

    // Full operation: latency counted in edges from the edge before the
    // accepting one, so done should appear after edge amt+1.
    task automatic run_op(input string tag, input logic [7:0] d, input logic [2:0] amt,
                          input logic sel, input logic [1:0] md, input logic cin,
                          input logic [7:0] exp_res, input logic exp_c);
        int  lat;
        int  busy_cycles;
        bit  seen;
        lat         = 1;
        busy_cycles = 0;
        seen        = 1'b0;
        issue(d, amt, sel, md, cin);
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            step();
            lat++;
        end
        check({tag, "_done_seen"}, 16'(seen), 16'd1);
        check({tag, "_latency"},   16'(lat), 16'(amt) + 16'd1);
        check({tag, "_busy_cnt"},  16'(busy_cycles), 16'(amt));
        check({tag, "_busy_in_done"}, 16'(busy), 16'd0);
        check({tag, "_result"},    16'(result), 16'(exp_res));
        check({tag, "_carry"},     16'(carry_out), 16'(exp_c));
        step();
        check({tag, "_done_pulse"}, 16'(done), 16'd0);
        check({tag, "_hold"},      16'(result), 16'(exp_res));
        check({tag, "_hold_c"},    16'(carry_out), 16'(exp_c));
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        D_in     = 8'h00;
        amount   = 3'd0;
        select   = 1'b0;
        mode     = 2'b00;
        carry_in = 1'b0;
        step();
        step();
        check("rst_result", 16'(result), 16'h00);
        check("rst_carry",  16'(carry_out), 16'd0);
        check("rst_busy",   16'(busy), 16'd0);
        check("rst_done",   16'(done), 16'd0);
        rst_n = 1'b1;
        step();

        // Logical left 3 of 1001_0110 -> 1011_0000, last out 0
        run_op("lsl3", 8'h96, 3'd3, 1'b0, 2'b00, 1'b0, 8'hB0, 1'b0);
        // Arithmetic right 2 of 1001_0110 -> 1110_0101, last out 1
        run_op("asr2", 8'h96, 3'd2, 1'b1, 2'b10, 1'b0, 8'hE5, 1'b1);
        // Rotate right 1 of 1000_0001 -> 1100_0000, out 1
        run_op("ror1", 8'h81, 3'd1, 1'b1, 2'b01, 1'b0, 8'hC0, 1'b1);
        // Rotate left 7 of 1000_0001 -> 1100_0000, last out 0
        run_op("rol7", 8'h81, 3'd7, 1'b0, 2'b01, 1'b1, 8'hC0, 1'b0);
        // Zero amount: passthrough of operand and carry_in
        run_op("zero", 8'h5A, 3'd0, 1'b0, 2'b00, 1'b1, 8'h5A, 1'b1);

        // Rotate-through-carry left 2 of 1000_0000, carry 0, with midpoint
        issue(8'h80, 3'd2, 1'b0, 2'b11, 1'b0);
        check("rcc_busy1", 16'(busy), 16'd1);
        step();
        check("rcc_mid_result", 16'(result), 16'h00);
        check("rcc_mid_carry",  16'(carry_out), 16'd1);
        step();
        check("rcc_done",   16'(done), 16'd1);
        check("rcc_result", 16'(result), 16'h01);
        check("rcc_carry",  16'(carry_out), 16'd0);
        step();

        // start during SHIFT is ignored: logical left 7 of 0x01 -> 0x80
        begin
            bit seen;
            seen = 1'b0;
            issue(8'h01, 3'd7, 1'b0, 2'b00, 1'b0);
            step();
            step();
            start  = 1'b1;
            D_in   = 8'hFF;
            amount = 3'd1;
            select = 1'b1;
            step();
            start  = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (done) begin
                    seen = 1'b1;
                    break;
                end
                step();
            end
            check("ign_done_seen", 16'(seen), 16'd1);
            check("ign_result",    16'(result), 16'h80);
            check("ign_carry",     16'(carry_out), 16'd0);
            step();
            check("ign_idle_busy", 16'(busy), 16'd0);
            check("ign_idle_done", 16'(done), 16'd0);
        end

        // Reset for one edge mid-SHIFT abandons the operation
        issue(8'hA5, 3'd5, 1'b1, 2'b01, 1'b1);
        step();
        step();
        check("mid_busy", 16'(busy), 16'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mrst_result", 16'(result), 16'h00);
        check("mrst_carry",  16'(carry_out), 16'd0);
        check("mrst_busy",   16'(busy), 16'd0);
        check("mrst_done",   16'(done), 16'd0);
        step();
        check("mrst_stay_idle", 16'(busy | done), 16'd0);

        // Operation after reset: rotate right 4 of 0011_1100 -> 1100_0011, last out 1
        run_op("post_rst", 8'h3C, 3'd4, 1'b1, 2'b01, 1'b0, 8'hC3, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
